// File: rtl/alu_32bit.sv
// -----------------------------------------------------------------------------
// alu_32bit
//   Single-cycle registered ALU. The result of op(a, b, f) is loaded into y on
//   every rising clk edge while reset is released. The operation decode is
//   purely combinational. The only state in the block is y.
//
//   f   | operation
//   000 | a & b
//   001 | a | b
//   010 | a + b            (carry-out dropped)
//   011 | a ^ b
//   100 | a & ~b
//   101 | a | ~b
//   110 | a - b            (a + ~b + 1, borrow dropped)
//   111 | signed a < b     (1 or 0, upper bits zero)
//
// Ports
//   clk : clock, rising edge
//   rst : asynchronous reset, active low (0 clears y)
//   a   : operand A, WIDTH bits
//   b   : operand B, WIDTH bits
//   f   : operation select, 3 bits
//   y   : registered result, WIDTH bits
// -----------------------------------------------------------------------------
module alu_32bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             slt;
    logic [WIDTH-1:0] result;

    assign sum  = a + b;
    assign diff = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};

    // Signed a - b overflows only when the operand signs differ and the sign
    // of the difference does not match a. The sign bit of the difference is
    // wrong exactly in that case, so flipping it gives the correct a < b.
    assign ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    assign slt = diff[WIDTH-1] ^ ovf;

    always_comb begin
        result = '0;
        case (f)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = sum;
            3'b011:  result = a ^ b;
            3'b100:  result = a & ~b;
            3'b101:  result = a | ~b;
            3'b110:  result = diff;
            3'b111:  result = {{(WIDTH-1){1'b0}}, slt};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else begin
            y <= result;
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// -----------------------------------------------------------------------------
// tb_alu_32bit
//   Bench for alu_32bit at WIDTH=8: reset behaviour, a directed vector table,
//   latency and asynchronous reset sequences, and random stimulus against a
//   reference model computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_32bit;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   f;
    logic [W-1:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] f;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    alu_32bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .f   (f),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: operands treated as integers in 0..255.
    function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic [2:0] mf);
        int ia, ib, sa, sb, r;
        ia = int'(ma);
        ib = int'(mb);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        case (mf)
            3'd0:    r = int'(ma & mb);
            3'd1:    r = int'(ma | mb);
            3'd2:    r = (ia + ib) % 256;
            3'd3:    r = int'(ma ^ mb);
            3'd4:    r = int'(ma & (8'hFF ^ mb));
            3'd5:    r = int'(ma | (8'hFF ^ mb));
            3'd6:    r = (ia - ib + 256) % 256;
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: y=0x%02h expected 0x%02h (a=0x%02h b=0x%02h f=%03b) t=%0t",
                     name, act, exp, a, b, f, $time);
        end
    endtask

    // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] tf);
        @(negedge clk);
        a = ta;
        b = tb;
        f = tf;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vf,
                           input logic [7:0] ve, input string vn);
        vec_t v;
        v.a = va; v.b = vb; v.f = vf; v.exp = ve; v.name = vn;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] ra, rb;
        logic [2:0] rf;

        // Directed table: opcode sweep, arithmetic wrap, signed compare, logic.
        add_vec(8'h00, 8'hFF, 3'b000, 8'h00, "sweep_and");
        add_vec(8'h00, 8'hFF, 3'b001, 8'hFF, "sweep_or");
        add_vec(8'h00, 8'hFF, 3'b010, 8'hFF, "sweep_add");
        add_vec(8'h00, 8'hFF, 3'b011, 8'hFF, "sweep_xor");
        add_vec(8'h00, 8'hFF, 3'b100, 8'h00, "sweep_andn");
        add_vec(8'h00, 8'hFF, 3'b101, 8'h00, "sweep_orn");
        add_vec(8'h00, 8'hFF, 3'b110, 8'h01, "sweep_sub");
        add_vec(8'h00, 8'hFF, 3'b111, 8'h00, "sweep_slt");
        add_vec(8'hFF, 8'h01, 3'b010, 8'h00, "add_wrap");
        add_vec(8'h00, 8'h01, 3'b110, 8'hFF, "sub_wrap");
        add_vec(8'h7F, 8'h01, 3'b010, 8'h80, "add_signovf");
        add_vec(8'h80, 8'h7F, 3'b111, 8'h01, "slt_neg_pos");
        add_vec(8'h7F, 8'h80, 3'b111, 8'h00, "slt_pos_neg");
        add_vec(8'h05, 8'h05, 3'b111, 8'h00, "slt_equal");
        add_vec(8'hFF, 8'h00, 3'b111, 8'h01, "slt_m1_0");
        add_vec(8'hA5, 8'h0F, 3'b000, 8'h05, "logic_and");
        add_vec(8'hA5, 8'h0F, 3'b001, 8'hAF, "logic_or");
        add_vec(8'hA5, 8'h0F, 3'b011, 8'hAA, "logic_xor");
        add_vec(8'hA5, 8'h0F, 3'b100, 8'hA0, "logic_andn");
        add_vec(8'hA5, 8'h0F, 3'b101, 8'hF5, "logic_orn");

        // Reset held with clock running and a nonzero result on the inputs.
        rst = 1'b0;
        a = 8'h12;
        b = 8'h34;
        f = 3'b010;
        #1;
        check("reset_initial", y, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", y, 8'h00);
        end

        // First edge after release loads the result directly.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_first_edge", y, 8'h46);

        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].f);
            check(vecs[i].name, y, vecs[i].exp);
        end

        // Latency: inputs change just after an edge; y holds until the next edge.
        apply(8'h12, 8'h34, 3'b010);
        check("latency_setup", y, 8'h46);
        held = y;
        a = 8'hA5;
        b = 8'h0F;
        f = 3'b011;
        #3;
        check("latency_hold", y, held);
        @(negedge clk);
        check("latency_hold_negedge", y, held);
        @(posedge clk);
        #1;
        check("latency_update", y, 8'hAA);

        // Asynchronous reset asserted between edges clears y at once.
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_clear", y, 8'h00);
        @(posedge clk);
        #1;
        check("async_reset_held", y, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        a = 8'h80;
        b = 8'h7F;
        f = 3'b111;
        @(posedge clk);
        #1;
        check("async_reset_release", y, 8'h01);

        // Random stimulus against the reference model.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rf = 3'($urandom_range(0, 7));
            if (i % 10 == 0) rb = ra;
            apply(ra, rb, rf);
            check("random", y, model(ra, rb, rf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
